// File: rtl/tent_key_sequencer_pkg.sv
// Shared definitions for the tent-map key sequencer and the tent-map core:
// controller state encoding and the precision mask used on every key value.
package tent_key_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Widest key the mask helper can serve; callers cast down to their width.
  localparam int MASK_W = 32;

  // sel 0/1/2/3 clears 0/2/4/6 LSBs: mask = ~((1 << 2*sel) - 1).
  function automatic logic [MASK_W-1:0] prec_mask(input logic [1:0] sel);
    prec_mask = ~((MASK_W'(1) << {sel, 1'b0}) - MASK_W'(1));
  endfunction

endpackage

// File: rtl/tent_key_sequencer.sv
// Iteration controller for the tent-map core. Latches seed/alpha/precision on
// start, runs one core iteration per CLEAR+RUN pair, feeds each masked key back
// as the next tent value, discards BURN_IN keys and streams the rest out.
//
// Output handshake: o_key_out/o_key_valid are registered and held stable while
// o_key_valid=1 and i_key_ready=0; a key transfers on the rising clk edge where
// o_key_valid and i_key_ready are both 1, and o_key_valid drops on that edge.
module tent_key_sequencer
  import tent_key_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16,
  parameter int BURN_IN    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic [DATA_WIDTH-1:0] i_alpha_in,
  input  logic [CNT_WIDTH-1:0]  i_num_keys,
  input  logic [1:0]            i_precision_sel,
  output logic                  o_flag2,
  output logic [DATA_WIDTH-1:0] o_tent,
  output logic [DATA_WIDTH-1:0] o_alpha,
  output logic [1:0]            o_core_prec_sel,
  input  logic [DATA_WIDTH-1:0] i_key3,
  input  logic                  i_done3,
  output logic [DATA_WIDTH-1:0] o_key_out,
  output logic                  o_key_valid,
  input  logic                  i_key_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output state_t                o_dbg_state
);

  localparam int                DROP_W   = (BURN_IN > 0) ? $clog2(BURN_IN + 1) : 1;
  localparam logic [DROP_W-1:0] DROP_LIM = DROP_W'(BURN_IN);
  localparam bit                HAS_BURN = (BURN_IN > 0);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_y;
  logic [DATA_WIDTH-1:0] r_alpha;
  logic [1:0]            r_sel;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [CNT_WIDTH-1:0]  r_emit_cnt;
  logic [DROP_W-1:0]     r_drop_cnt;
  logic [DATA_WIDTH-1:0] r_key_out;
  logic                  r_key_valid;
  logic                  r_flag2;
  logic                  r_done;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] w_start_mask;
  logic [DATA_WIDTH-1:0] w_seed_masked;
  logic                  w_start_bad;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_k;
  logic                  w_drop;
  logic                  w_key_fire;
  logic                  w_last;

  // Start-time checks use the incoming sel; the run itself uses the latched sel.
  assign w_start_mask  = DATA_WIDTH'(prec_mask(i_precision_sel));
  assign w_seed_masked = i_seed & w_start_mask;
  assign w_start_bad   = (i_alpha_in == '0) || (w_seed_masked == '0);

  assign w_mask     = DATA_WIDTH'(prec_mask(r_sel));
  assign w_k        = i_key3 & w_mask;
  assign w_drop     = HAS_BURN && (r_drop_cnt != DROP_LIM);
  assign w_key_fire = (r_state == ST_EMIT) && r_key_valid && i_key_ready;
  // Full-width compare plus one guard bit so num_keys = all-ones never wraps.
  assign w_last     = ({1'b0, r_emit_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, r_num};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_start_bad || (i_num_keys == '0)) w_next_state = ST_FINISH;
          else                                   w_next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: w_next_state = ST_RUN;
      ST_RUN: begin
        if (i_done3) begin
          if (w_k == '0)  w_next_state = ST_FINISH;
          else if (w_drop) w_next_state = ST_CLEAR;
          else             w_next_state = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_key_fire) w_next_state = w_last ? ST_FINISH : ST_CLEAR;
      end
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: run parameters, y feedback, counters, key output and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y         <= '0;
      r_alpha     <= '0;
      r_sel       <= '0;
      r_num       <= '0;
      r_emit_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_flag2     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // flag2 is high exactly while in RUN; done is high exactly while in FINISH.
      r_flag2 <= (w_next_state == ST_RUN);
      r_done  <= (w_next_state == ST_FINISH);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_alpha    <= i_alpha_in;
            r_sel      <= i_precision_sel;
            r_num      <= i_num_keys;
            r_y        <= w_seed_masked;
            r_err      <= w_start_bad;
            r_emit_cnt <= '0;
            r_drop_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (i_done3) begin
            r_y <= w_k;
            if (w_k == '0) begin
              r_err <= 1'b1;
            end else if (w_drop) begin
              r_drop_cnt <= r_drop_cnt + 1'b1;
            end else begin
              r_key_out   <= w_k;
              r_key_valid <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (w_key_fire) begin
            r_key_valid <= 1'b0;
            r_emit_cnt  <= r_emit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_flag2         = r_flag2;
  assign o_tent          = r_y;
  assign o_alpha         = r_alpha;
  assign o_core_prec_sel = r_sel;
  assign o_key_out       = r_key_out;
  assign o_key_valid     = r_key_valid;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_dbg_state     = r_state;

endmodule
